// File: rtl/control_fifo_pack.sv
// Width-packing FWFT FIFO: RATIO narrow beats are packed little-endian into one wide word,
// with programmable thresholds, partial-word flush, sticky error flags and read-side level.
module control_fifo_pack #(
   parameter int unsigned IN_W  = 8,
   parameter int unsigned RATIO = 32,
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AF_TH = 960,
   parameter int unsigned AE_TH = 1,
   parameter int unsigned LW    = $clog2(DEPTH*RATIO+1),
   localparam int unsigned OUT_W = IN_W*RATIO,
   localparam int unsigned CW    = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  din,
   input  logic             wrreq,
   input  logic             flush,
   output logic [OUT_W-1:0] dout,
   input  logic             ready,
   output logic             empty,
   output logic             full,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [LW-1:0]    wr_water_level,
   output logic [CW-1:0]    rd_level,
   output logic             overflow,
   output logic             underflow,
   input  logic             clear_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = (RATIO > 1) ? $clog2(RATIO) : 1;

   logic [OUT_W-1:0] mem_q [DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    word_cnt_q, word_cnt_d;
   logic [PW-1:0]    pack_cnt_q, pack_cnt_d;
   logic [OUT_W-1:0] packer_q, packer_d;
   logic [OUT_W-1:0] dout_q, dout_d;
   logic [LW-1:0]    wr_lvl_q, wr_lvl_d;
   logic             empty_q, empty_d, full_q, full_d;
   logic             af_q, af_d, ae_q, ae_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;

   logic             wr_acc, pop, commit;
   logic [OUT_W-1:0] commit_word;

   always_comb begin
      wr_acc = wrreq && !full_q;
      pop    = ready && !empty_q;

      // Lanes above pack_cnt are always zero, so a flushed word is zero padded for free.
      commit_word = packer_q;
      if (wr_acc) begin
         commit_word[pack_cnt_q*IN_W +: IN_W] = din;
      end

      commit = (wr_acc && (pack_cnt_q == PW'(RATIO-1)))
               || (flush && (wr_acc || (pack_cnt_q != '0)));

      if (commit) begin
         pack_cnt_d = '0;
      end else if (wr_acc) begin
         pack_cnt_d = pack_cnt_q + PW'(1);
      end else begin
         pack_cnt_d = pack_cnt_q;
      end
      packer_d = commit ? '0 : commit_word;

      wr_ptr_d   = wr_ptr_q + AW'(commit);
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      word_cnt_d = word_cnt_q + CW'(commit) - CW'(pop);

      // Bypass the word being written when it lands in the next head slot.
      if (commit && (wr_ptr_q == rd_ptr_d)) begin
         dout_d = commit_word;
      end else begin
         dout_d = mem_q[rd_ptr_d];
      end

      wr_lvl_d = LW'(word_cnt_d) * LW'(RATIO) + LW'(pack_cnt_d);
      empty_d  = (word_cnt_d == '0);
      full_d   = (word_cnt_d == CW'(DEPTH));
      af_d     = (32'(wr_lvl_d) >= AF_TH);
      ae_d     = (32'(word_cnt_d) <= AE_TH);

      ovf_d = (wrreq && full_q) || (ovf_q && !clear_err);
      unf_d = (ready && empty_q) || (unf_q && !clear_err);
   end

   always_ff @(posedge clk) begin
      if (commit) begin
         mem_q[wr_ptr_q] <= commit_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         word_cnt_q <= '0;
         pack_cnt_q <= '0;
         packer_q   <= '0;
         dout_q     <= '0;
         wr_lvl_q   <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         af_q       <= 1'b0;
         ae_q       <= 1'b1;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         word_cnt_q <= word_cnt_d;
         pack_cnt_q <= pack_cnt_d;
         packer_q   <= packer_d;
         dout_q     <= dout_d;
         wr_lvl_q   <= wr_lvl_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         af_q       <= af_d;
         ae_q       <= ae_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   assign dout           = dout_q;
   assign empty          = empty_q;
   assign full           = full_q;
   assign almost_full    = af_q;
   assign almost_empty   = ae_q;
   assign wr_water_level = wr_lvl_q;
   assign rd_level       = word_cnt_q;
   assign overflow       = ovf_q;
   assign underflow      = unf_q;

endmodule
